// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: the pipeline hazard and redirect inputs, plus the fetch and decode PC outputs.
// master = sequencer side, slave = pipeline/memory side.
interface pc_sequencer_if;
   logic        stall;
   logic        jal_valid;
   logic [31:0] jal_target;
   logic        ex_redirect;
   logic [31:0] ex_target;
   logic [31:0] pc;
   logic [31:0] pc_id;
   logic        id_valid;
   logic        flush_id;
   logic        misalign;

   modport master (
      input  stall, jal_valid, jal_target, ex_redirect, ex_target,
      output pc, pc_id, id_valid, flush_id, misalign
   );

   modport slave (
      output stall, jal_valid, jal_target, ex_redirect, ex_target,
      input  pc, pc_id, id_valid, flush_id, misalign
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC register, next-PC selection and decode-slot valid/kill control for a 3-stage pipeline.
// Optional macro MISALIGN_TRAP_EN: misaligned redirect/JAL targets go to TRAP_PC and pulse misalign.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_2000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_1000
) (
   input logic            clk,
   input logic            rst,
   pc_sequencer_if.master bus
);
   typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic        misalign_q, misalign_d;

   logic        id_valid;
   logic        jal_accept;
   logic [31:0] target;
   logic        target_misaligned;

   // Decode holds a real instruction only in RUN; BOOT and BUBBLE are both empty slots.
   assign id_valid   = (state_q == RUN);
   assign jal_accept = bus.jal_valid & id_valid & ~bus.stall;
   assign target     = bus.ex_redirect ? bus.ex_target : bus.jal_target;

`ifdef MISALIGN_TRAP_EN
   assign target_misaligned = |target[1:0];
`else
   assign target_misaligned = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_id_d    = pc_id_q;
      misalign_d = 1'b0;
      case (state_q)
         BOOT, RUN, BUBBLE: begin
            // Execute redirect outranks stall and a same-cycle JAL.
            if (bus.ex_redirect || jal_accept) begin
               pc_d       = target_misaligned ? TRAP_PC : target;
               pc_id_d    = pc_q;
               misalign_d = target_misaligned;
               state_d    = BUBBLE;
            end else if (!bus.stall) begin
               pc_d    = pc_q + 32'd4;
               pc_id_d = pc_q;
               state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         pc_id_q    <= 32'd0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_id_q    <= pc_id_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc_id    = pc_id_q;
   assign bus.id_valid = id_valid;
   assign bus.flush_id = bus.ex_redirect & ~rst;
   assign bus.misalign = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a cycle-level reference model pushes expectations,
// two monitors (registered outputs after the edge, flush_id after each drive) pop and compare.
module tb_pc_sequencer;
   localparam logic [31:0] RESET_PC = 32'h0000_2000;
   localparam logic [31:0] TRAP_PC  = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst;
   pc_sequencer_if bus();

   pc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc_id;
      logic        id_known;
      logic        valid;
      logic        mis;
   } exp_t;

   exp_t seq_q[$];
   bit   flush_q[$];
   event drv_ev;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cyc    = 0;

   // Reference model state: what the fetch/decode slots should hold after the next edge.
   logic [31:0] m_pc = '0, m_pc_id = '0;
   logic        m_valid = 1'b0, m_known = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, n_cyc);
      end
   endtask

   task automatic step(input bit r, input bit st, input bit jv, input logic [31:0] jt,
                       input bit er, input logic [31:0] et);
      exp_t        e;
      logic [31:0] tgt;
      bit          bad;
      @(negedge clk);
      rst = r; bus.stall = st; bus.jal_valid = jv; bus.jal_target = jt;
      bus.ex_redirect = er; bus.ex_target = et;
      flush_q.push_back(er && !r);
      e.mis = 1'b0;
      if (r) begin
         m_pc = RESET_PC; m_pc_id = '0; m_known = 1'b1; m_valid = 1'b0;
      end else if (er || (jv && m_valid && !st)) begin
         tgt = er ? et : jt;
`ifdef MISALIGN_TRAP_EN
         bad = (tgt[1:0] != 2'b00);
`else
         bad = 1'b0;
`endif
         if (!st) begin m_pc_id = m_pc; m_known = 1'b1; end
         else m_known = 1'b0;
         m_pc    = bad ? TRAP_PC : tgt;
         e.mis   = bad;
         m_valid = 1'b0;
      end else if (!st) begin
         m_pc_id = m_pc; m_known = 1'b1; m_pc = m_pc + 32'd4; m_valid = 1'b1;
      end
      e.pc = m_pc; e.pc_id = m_pc_id; e.id_known = m_known; e.valid = m_valid;
      seq_q.push_back(e);
      ->drv_ev;
   endtask

   // Registered outputs: one expectation per clock edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (seq_q.size() > 0) begin
         e = seq_q.pop_front();
         n_cyc++;
         check("pc", bus.pc, e.pc);
         check("id_valid", {31'd0, bus.id_valid}, {31'd0, e.valid});
         check("misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
         if (e.id_known) check("pc_id", bus.pc_id, e.pc_id);
         $display("cyc %0d pc=%h pc_id=%h id_valid=%0b misalign=%0b", n_cyc, bus.pc,
                  bus.pc_id, bus.id_valid, bus.misalign);
      end
   end

   // Combinational kill: checked once the new inputs have settled.
   always @(drv_ev) begin
      bit f;
      #1;
      if (flush_q.size() > 0) begin
         f = flush_q.pop_front();
         check("flush_id", {31'd0, bus.flush_id}, {31'd0, f});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t;
      rst = 1'b1; bus.stall = 1'b0; bus.jal_valid = 1'b0; bus.jal_target = '0;
      bus.ex_redirect = 1'b0; bus.ex_target = '0;

      // Reset release, sequential fetch
      step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      // JAL in decode at pc_id=0x2004
      step(0, 0, 1, 32'h2100, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      // Redirect together with JAL and stall
      step(0, 1, 1, 32'h2200, 1, 32'h3000);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      // Stall held three cycles at pc=0x2008
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // Wrap from 0xFFFF_FFFC
      step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      // Reset in the bubble right after a redirect
      step(0, 0, 0, 0, 1, 32'h4000);
      step(1, 0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      // Misaligned execute target
      step(0, 0, 0, 0, 1, 32'h3002);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      // Misaligned JAL target, then JAL offered while stalled and in a bubble
      step(0, 0, 1, 32'h5001, 0, 0);
      step(0, 0, 1, 32'h6000, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 32'h7000, 0, 0);
      step(0, 0, 1, 32'h7000, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         t = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, t, $urandom_range(0, 8) == 0,
              {$urandom, ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00} >> 2);
      end

      step(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(seq_q.size() + flush_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch PC register for the three-stage RISC-V pipeline.
- Selects the next fetch address from four sources: reset vector, sequential PC+4, a decode-stage JAL target, and an execute-stage redirect (taken branch or JALR).
- Tracks the PC and validity of the instruction in decode, and generates the kill/bubble control for wrong-path fetches.
- Sits between the jump-address generator, the execute stage and the synchronous instruction memory (one-cycle read latency).

Parameters:
RESET_PC, 32'h0000_2000, fetch address driven in the first cycle after reset
TRAP_PC, 32'h0000_1000, redirect address for a misaligned target (optional feature only)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold fetch PC and decode contents (hazard/memory wait)
jal_valid  input  1  decode instruction is JAL; qualified internally with id_valid
jal_target  input  32  JAL target computed from the decode instruction
ex_redirect  input  1  execute stage resolved a taken branch or JALR
ex_target  input  32  redirect address from execute
pc  output  32  current fetch address to IMEM
pc_id  output  32  PC of the instruction currently in decode
id_valid  output  1  decode instruction is real (0 = bubble)
flush_id  output  1  combinational kill of the current decode instruction
misalign  output  1  one-cycle pulse on a misaligned target (optional feature only, else tied 0)

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, pc_id=0, id_valid=0, state=BOOT.
  - Overrides everything, including a mid-redirect or mid-stall.
- Memory timing: IMEM returns inst(pc) one cycle later, so pc_id(t+1)=pc(t) whenever not stalled.
- Next-PC priority (highest first): rst > ex_redirect > (jal_valid & id_valid & !stall) > stall > pc+4.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). Targets are used unmodified; no bit clearing.
- ex_redirect ignores stall:
  - pc<=ex_target, flush_id=1 in the same cycle, id_valid<=0 next cycle.
  - Two bubbles total.
- Accepted JAL:
  - pc<=jal_target, id_valid<=0 next cycle.
  - flush_id=0, because the JAL itself retires.
  - One bubble.
- jal_valid while id_valid=0 or stall=1 is ignored. A stalled JAL is re-presented after the stall.
- Stall without redirect: pc, pc_id and id_valid all hold.
- FSM:
  - BOOT: first cycle after reset; id_valid=0; go to RUN unless stall, in which case stay in BOOT.
  - RUN: normal operation; id_valid<=1 each unstalled cycle; go to BUBBLE on ex_redirect or accepted JAL.
  - BUBBLE: id_valid=0 this cycle; go to RUN next cycle.
    - ex_redirect in BUBBLE re-enters BUBBLE with the new target.
    - jal_valid in BUBBLE is ignored.
    - stall in BUBBLE holds state.
- flush_id = ex_redirect & !rst, purely combinational.
- Simultaneous ex_redirect and jal_valid: execute wins and the JAL is killed.
- ex_redirect in the same cycle as stall: redirect taken, stall ignored for the PC.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: if an accepted target (ex_target or jal_target) has bits[1:0]!=0:
  - pc<=TRAP_PC.
  - misalign pulses 1 for one cycle, aligned with the PC update.
  - Bubble rules are identical to a normal redirect.
- Undefined: targets are loaded as-is, misalign is constant 0, and TRAP_PC is unused.

Test Plan:
- Reset release, no stall, 4 cycles -> pc = 0x2000, 0x2004, 0x2008, 0x200C; id_valid = 0, 1, 1, 1; pc_id lags pc by one.
- JAL in decode at pc_id=0x2004, jal_target=0x2100 -> next pc=0x2100, id_valid=0 for one cycle, then pc_id=0x2100 with id_valid=1; flush_id stays 0.
- ex_redirect=1, ex_target=0x3000, asserted together with jal_valid and stall -> flush_id=1 that cycle; pc=0x3000 next; id_valid=0 then 1 with pc_id=0x3000.
- stall held 3 cycles at pc=0x2008 -> pc and pc_id frozen; release -> pc=0x200C. Separately, pc=0xFFFF_FFFC sequential -> pc=0x0000_0000.
- rst asserted in BUBBLE immediately after a redirect -> pc=0x2000, id_valid=0, state BOOT; the pending target is discarded.
- With MISALIGN_TRAP_EN defined: ex_target=0x3002 -> pc=0x1000, misalign=1 for exactly one cycle. Without the macro: pc=0x3002, misalign=0.
